// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: turns 32-bit word requests into four little-endian byte
// accesses on a zero-latency synchronous byte SRAM, with write strobes and
// misalignment detection. Request and response use valid/ready handshakes.
module sram_word_ctrl #(
    parameter int unsigned alen = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [alen-1:0] req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [3:0]      req_wstrb,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic            sram_re,
    output logic            sram_we,
    output logic [alen-1:0] sram_addr,
    output logic [7:0]      sram_wdata,
    input  logic [7:0]      sram_rdata
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             accept;

    logic             we_q;
    logic [alen-1:0]  addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    // State and byte-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and port drive; reset forces every output low in the same cycle
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    cnt_n   = '0;
                    state_n = (req_addr[1:0] != 2'b00) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                sram_addr  = (addr_q & ~alen'(3)) | alen'(cnt);
                sram_re    = ~we_q;
                sram_we    = we_q & wstrb_q[cnt];
                sram_wdata = we_q ? wdata_q[{cnt, 3'b000} +: BYTE_W] : 8'h00;
                cnt_n      = cnt + CNT_W'(1);
                if (cnt == CNT_W'(3)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (rst) begin
            accept     = 1'b0;
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = '0;
            sram_re    = 1'b0;
            sram_we    = 1'b0;
            sram_addr  = '0;
            sram_wdata = '0;
        end
    end

    // Request latch and read-byte assembly; unread lanes stay zero
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            rdata_q <= '0;
            err_q   <= (req_addr[1:0] != 2'b00);
        end else if (state == ACCESS && !we_q) begin
            rdata_q[{cnt, 3'b000} +: BYTE_W] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a byte-array memory model.
module tb_sram_word_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          sram_re;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic [7:0]    sram_rdata;

    sram_word_ctrl #(.alen(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Byte SRAM; an undriven read bus is modelled as a poison pattern
    logic [7:0] mem [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       mem_clr;
    assign sram_rdata = (sram_re && !sram_we) ? mem[sram_addr] : 8'hA5;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
        end else if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
        end
    end

    int cyc = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    int we_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM activity monitor
    always @(negedge clk) begin
        if (sram_re) re_cnt++;
        if (sram_we) begin
            we_cnt++;
            we_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: word access on a flat byte array
    function automatic logic [31:0] ref_access(input logic we, input logic [AW-1:0] a,
                                               input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w = 32'h0;
        if (a[1:0] != 2'b00) return 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (we) begin
                if (s[i]) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                w[8*i +: 8] = ref_mem[int'(a) + i];
            end
        end
        return w;
    endfunction

    // One transaction; called and returns just after a falling edge
    task automatic txn(input string name, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp_rd,
                       input logic exp_err, input int hold, input logic busy, output int acc);
        int n;
        int lat;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_wstrb  = ws;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, " accept"}, 32'(req_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = busy;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'd5);
        chk({name, " rdata"}, resp_rdata, exp_rd);
        chk({name, " err"}, 32'(resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold valid"}, 32'(resp_valid), 32'd1);
            chk({name, " hold rdata"}, resp_rdata, exp_rd);
            chk({name, " hold err"}, 32'(resp_err), 32'(exp_err));
            chk({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    ws;
        logic [31:0]   exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t vt[10];

    initial begin
        int acc, acc2, pacc, pgap, r0, w0, s0, n, cnt, bad;
        logic rwe, ee, b;
        logic [AW-1:0] a;
        logic [31:0] d, e;
        logic [3:0] s;
        int h;

        vt[0] = '{1'b1, 10'h010, 32'h11223344, 4'hF, 32'h00000000, 1'b0};
        vt[1] = '{1'b0, 10'h010, 32'h0,        4'h0, 32'h11223344, 1'b0};
        vt[2] = '{1'b1, 10'h020, 32'hAABBCCDD, 4'hF, 32'h00000000, 1'b0};
        vt[3] = '{1'b1, 10'h020, 32'h55667788, 4'h5, 32'h00000000, 1'b0};
        vt[4] = '{1'b0, 10'h020, 32'h0,        4'h0, 32'hAA66CC88, 1'b0};
        vt[5] = '{1'b0, 10'h031, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vt[6] = '{1'b1, 10'h032, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
        vt[7] = '{1'b1, 10'h050, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
        vt[8] = '{1'b1, 10'h050, 32'h12345678, 4'h0, 32'h00000000, 1'b0};
        vt[9] = '{1'b0, 10'h050, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;

        // Outputs held low throughout reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset req_ready", 32'(req_ready), 32'd0);
            chk("reset resp", {resp_rdata[29:0], resp_valid, resp_err}, 32'd0);
            chk("reset sram", {12'(sram_addr), sram_wdata, 10'd0, sram_re, sram_we}, 32'd0);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            r0 = re_cnt; w0 = we_cnt; s0 = we_cyc.size();
            e = ref_access(vt[i].we, vt[i].addr, vt[i].wd, vt[i].ws);
            txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wd, vt[i].ws,
                vt[i].exp_rd, vt[i].exp_err, 0, 1'b0, acc);
            chk($sformatf("vec%0d sram_re count", i), 32'(re_cnt - r0),
                (!vt[i].exp_err && !vt[i].we) ? 32'd4 : 32'd0);
            chk($sformatf("vec%0d sram_we count", i), 32'(we_cnt - w0),
                (!vt[i].exp_err && vt[i].we) ? 32'($countones(vt[i].ws)) : 32'd0);
            if (i == 3 && we_cyc.size() >= s0 + 2) begin
                chk("strobe pulse byte0", 32'(we_cyc[s0]), 32'(acc + 1));
                chk("strobe pulse byte2", 32'(we_cyc[s0 + 1]), 32'(acc + 3));
            end
        end
        chk("sram bytes 0x010..0x013", {mem[19], mem[18], mem[17], mem[16]}, 32'h11223344);

        // Response held under backpressure while the next request waits
        e = ref_access(1'b1, 10'h060, 32'h01020304, 4'hF);
        txn("hold_w", 1'b1, 10'h060, 32'h01020304, 4'hF, 32'h0, 1'b0, 10, 1'b1, acc);
        e = ref_access(1'b0, 10'h060, 32'h0, 4'h0);
        txn("hold_r", 1'b0, 10'h060, 32'h0, 4'h0, 32'h01020304, 1'b0, 0, 1'b0, acc2);
        chk("accept after handshake", 32'(acc2 - acc), 32'd16);

        // Reset during byte 2 of a write aborts it
        e = ref_access(1'b1, 10'h040, 32'h0, 4'hF);
        txn("rst_prefill", 1'b1, 10'h040, 32'h0, 4'hF, 32'h0, 1'b0, 0, 1'b0, acc);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h040; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid sram_we", 32'(sram_we), 32'd0);
        chk("rst_mid req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid req_ready after", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) cnt++;
            @(negedge clk);
        end
        chk("rst_mid no response", 32'(cnt), 32'd0);
        chk("rst_mid sram bytes", {mem[67], mem[66], mem[65], mem[64]}, 32'h0000BEEF);
        ref_mem[64] = 8'hEF;
        ref_mem[65] = 8'hBE;
        txn("rst_mid readback", 1'b0, 10'h040, 32'h0, 4'h0, 32'h0000BEEF, 1'b0, 0, 1'b0, acc);

        // Reset during RESP drops the pending response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp pending", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp dropped", {30'd0, resp_valid, req_ready}, 32'd1);

        // Back-to-back reads at the top aligned address
        e = ref_access(1'b1, AW'(DEPTH - 4), 32'h0BADF00D, 4'hF);
        txn("top_w", 1'b1, AW'(DEPTH - 4), 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0, 1'b0, acc);
        chk("top byte", 32'(mem[DEPTH - 1]), 32'h0B);
        txn("top_r0", 1'b0, AW'(DEPTH - 4), 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0, 1'b0, acc);
        txn("top_r1", 1'b0, AW'(DEPTH - 4), 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0, 1'b0, acc2);
        chk("top throughput", 32'(acc2 - acc), 32'd6);

        // Randomized traffic against the memory model
        pacc = 0; pgap = 0;
        for (int k = 0; k < 150; k++) begin
            rwe = 1'($urandom_range(0, 1));
            a   = AW'(12'h200 + 12'($urandom_range(0, 31)) * 12'd4);
            if ($urandom_range(0, 7) == 0) a = a | AW'($urandom_range(1, 3));
            d   = $urandom;
            s   = 4'($urandom);
            h   = $urandom_range(0, 2);
            b   = 1'($urandom_range(0, 1));
            ee  = (a[1:0] != 2'b00);
            e   = ref_access(rwe, a, d, s);
            r0 = re_cnt; w0 = we_cnt;
            txn($sformatf("rnd%0d", k), rwe, a, d, s, e, ee, h, b, acc);
            chk($sformatf("rnd%0d sram_re count", k), 32'(re_cnt - r0), (!ee && !rwe) ? 32'd4 : 32'd0);
            chk($sformatf("rnd%0d sram_we count", k), 32'(we_cnt - w0),
                (!ee && rwe) ? 32'($countones(s)) : 32'd0);
            if (k > 0) chk($sformatf("rnd%0d accept gap", k), 32'(acc - pacc), 32'(pgap));
            pacc = acc;
            pgap = (ee ? 1 : 5) + h + 1;
        end

        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("memory image mismatching bytes", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Simulation-side initiator that turns 32-bit word requests from a bus master into sequences of byte-wide accesses on a zero-latency synchronous byte SRAM port. It sits between a core-side memory model and the byte SRAM in the simulated device tree. It performs the 4-byte little-endian split and reassembly, applies write byte strobes, and flags misaligned requests. Request and response use valid/ready handshakes.

## Interface
- `alen`, default 10: SRAM byte address width. Must be ≥ 2.
- `clk`, in, 1: clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: controller accepts a request. High only in IDLE and only while `rst` is low.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, alen: byte address. Bits [1:0] must be 0.
- `req_wdata`, in, 32: write data, little-endian.
- `req_wstrb`, in, 4: write byte enables. Bit i covers byte i.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: master accepts the response.
- `resp_rdata`, out, 32: read data. 0 for writes and for errors.
- `resp_err`, out, 1: request was misaligned.
- `sram_re`, out, 1: SRAM read enable.
- `sram_we`, out, 1: SRAM write enable.
- `sram_addr`, out, alen: SRAM byte address.
- `sram_wdata`, out, 8: SRAM write data.
- `sram_rdata`, in, 8: SRAM read data. Combinationally valid while `sram_re && !sram_we`; high-Z otherwise.

## Operation
- States: IDLE, ACCESS, RESP.
- Request is accepted on a cycle with `req_valid && req_ready`. The controller latches `req_we`, `req_addr`, `req_wdata` and `req_wstrb`.
- Accepted request in IDLE:
  - `req_addr[1:0] != 0`: go to RESP with `resp_err=1` and `resp_rdata=0`. No SRAM access is made.
  - Otherwise: go to ACCESS with the 2-bit byte counter at 0.
- ACCESS, byte i (counter value i):
  - `sram_addr = {addr[alen-1:2], i}`.
  - Read: `sram_re=1`, `sram_we=0`. `sram_rdata` is captured into `rdata[8i+7:8i]` at the end of the cycle.
  - Write: `sram_we = wstrb[i]`, `sram_re=0`, `sram_wdata = wdata[8i+7:8i]`.
  - After i=3, go to RESP. Every access takes exactly 4 cycles, whatever the strobes.
- RESP: `resp_valid=1`. Response fields stay stable until `resp_ready`. On handshake, go to IDLE.
- Outside ACCESS: `sram_re=0`, `sram_we=0`, `sram_addr=0`, `sram_wdata=0`.
- Byte lanes never captured from SRAM (writes, errors) read as 0.
- Outputs during and after reset: `req_ready=0` while `rst` is high; `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, all `sram_*` outputs 0, state IDLE, counter 0.
- Reset mid-ACCESS aborts the access. Bytes already written stay written, and `sram_we` is 0 from the cycle after reset is sampled. Reset during RESP drops the pending response.
- Write with `wstrb=4'b0000`: 4 ACCESS cycles with no SRAM write, then a normal response.
- There is no address wrap. An aligned base address + 3 always lies within the SRAM depth.

## Timing
- Accept at cycle T. ACCESS covers T+1..T+4, for bytes 0..3. `resp_valid` rises at T+5.
- If `resp_ready` is high at T+5, `req_ready` is high again at T+6. Throughput is one word per 6 cycles.
- Misaligned request accepted at T: `resp_valid`/`resp_err` at T+1, `req_ready` again at T+2 if `resp_ready` is held high.
- `resp_ready` low holds RESP indefinitely, and `req_ready` stays 0 for that time.
- `req_ready` is a function of state and `rst` only. It never depends on `req_valid`.
- `req_*` inputs are ignored outside the accept cycle.

## Test plan
- Write 0x11223344 with wstrb=4'hF to addr 0x010, then read addr 0x010 → SRAM bytes 0x10..0x13 = 44,33,22,11. Read response `resp_rdata=0x11223344`, `resp_err=0`. `resp_valid` at exactly accept+5 for both transactions.
- Pre-fill addr 0x020 with 0xAABBCCDD. Write 0x55667788 with wstrb=4'b0101 → read returns 0xAA66CC88. `sram_we` pulses only in ACCESS cycles 0 and 2.
- Read addr 0x031 → `resp_err=1` and `resp_rdata=0` at accept+1. `sram_re` and `sram_we` stay 0 throughout.
- Hold `resp_ready=0` for 10 cycles after `resp_valid` while `req_valid=1` → response stays stable and `req_ready` stays 0. Raise `resp_ready` → the next request is accepted 1 cycle after the handshake.
- Assert `rst` for 1 cycle during ACCESS byte 2 of a wstrb=4'hF write of 0xDEADBEEF to 0x040 (pre-filled with 0) → bytes 0x040 and 0x041 hold EF and BE, 0x042 and 0x043 stay 00. No `resp_valid` follows, and `req_ready` is 1 the cycle after `rst` falls.
- Back-to-back reads of max aligned address (depth-4) with `resp_ready` tied high → correct data, one response every 6 cycles, top byte at address depth-1.
